// File: rtl/rom_rr_arbiter_pkg.sv
// Shared defaults and id type for the round-robin ROM arbiter.
// Optional statistics counters are enabled with the ROM_ARB_STATS_EN macro.
package rom_arb_pkg;
    localparam int NUM_REQ_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int IDX_WIDTH      = $clog2(NUM_REQ_DEF);

    typedef logic [IDX_WIDTH-1:0] req_id_t;
endpackage

// File: rtl/rom_rr_arbiter_if.sv
// Requester/ROM bus seen by the arbiter: requests, grants, ROM address/data, responses.
interface rom_arb_if
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [DATA_WIDTH-1:0]         rom_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_addr, rom_data,
        output req_ready, rom_addr, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_addr, rom_data,
        input  req_ready, rom_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rom_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rom_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   id,
    output logic               any
);
    always_comb begin
        logic [IDX_W-1:0] sel;
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant = '0;
        id    = '0;
        any   = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                id         = sel;
            end
        end
    end
endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM between NUM_REQ requesters.
// Define ROM_ARB_STATS_EN to add saturating per-requester grant counters.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef ROM_ARB_STATS_EN
    , parameter int CNT_WIDTH = CNT_WIDTH_DEF
`endif
) (
    input  logic clock,
    input  logic reset,
`ifdef ROM_ARB_STATS_EN
    input  logic                           stats_clear,
    output logic [NUM_REQ*CNT_WIDTH-1:0]   grant_count,
`endif
    rom_arb_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      win_id;
    logic [IDX_W-1:0]      rsp_id;
    logic                  rsp_pend;
    logic                  any_req;
    logic [NUM_REQ-1:0]    grant;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [ADDR_WIDTH-1:0] last_addr;

    rom_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (win_id),
        .any   (any_req)
    );

    assign win_addr      = bus.req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.req_ready = grant;
    // Idle cycles keep presenting the last granted address so the ROM input stays quiet.
    assign bus.rom_addr  = any_req ? win_addr : last_addr;
    assign bus.rsp_valid = rsp_pend ? (NUM_REQ'(1) << rsp_id) : '0;
    assign bus.rsp_data  = bus.rom_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            rsp_id    <= '0;
            rsp_pend  <= 1'b0;
            last_addr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            rsp_pend <= any_req;
            if (any_req) begin
                rsp_id    <= win_id;
                last_addr <= win_addr;
                rr_ptr    <= (win_id == IDX_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            end
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

    // NOTE: the counter array is a small register file, so it takes the async reset like any flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (stats_clear) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end
`endif
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter with a behavioural registered ROM and reference model.
// Build with ROM_ARB_STATS_EN defined to also exercise the grant counters.
module tb_rom_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    rom_arb_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef ROM_ARB_STATS_EN
    logic          stats_clear;
    logic [N*4-1:0] grant_count;
`endif

    rom_rr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
`ifdef ROM_ARB_STATS_EN
        , .CNT_WIDTH(4)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef ROM_ARB_STATS_EN
        .stats_clear (stats_clear),
        .grant_count (grant_count),
`endif
        .bus         (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {27'b0, a};
        return 32'hD3301861 ^ (x * 32'h9E3779B9);
    endfunction

    // Behavioural ROM: registered output, one-cycle latency, no reset.
    always @(posedge clock) bus.rom_data <= rom_word(bus.rom_addr);

    // Reference model state.
    int          m_ptr;
    bit          m_pend;
    int          m_pend_id;
    logic [AW-1:0] m_pend_addr;
    logic [AW-1:0] m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner is the active requester at the smallest circular distance from the pointer.
    function automatic int model_winner(input logic [N-1:0] v);
        int best, bestd, d;
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (v[i] && d < bestd) begin best = i; bestd = d; end
        end
        return best;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a, output logic [N-1:0] seen);
        int w;
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] exp_addr;
        bus.req_valid = v;
        bus.req_addr  = a;
        #3;
        w = model_winner(v);
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        exp_addr  = (w >= 0) ? a[w*AW +: AW] : m_last;
        check("req_ready", bus.req_ready, exp_ready);
        check("rom_addr", bus.rom_addr, exp_addr);
        if (m_pend) begin
            check("rsp_valid", bus.rsp_valid, N'(1) << m_pend_id);
            check("rsp_data", bus.rsp_data, rom_word(m_pend_addr));
        end else begin
            check("rsp_valid_idle", bus.rsp_valid, 0);
        end
        seen = bus.req_ready;
        if (w >= 0) begin
            m_ptr = (w + 1) % N; m_pend = 1'b1; m_pend_id = w;
            m_pend_addr = exp_addr; m_last = exp_addr;
        end else begin
            m_pend = 1'b0;
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        reset = 1'b1;
        m_ptr = 0; m_pend = 1'b0; m_last = '0;
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  ready;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t tab [14];

    initial begin
        logic [N-1:0]    seen, prev_ready, v;
        logic [N*AW-1:0] a, tab_addrs;
        logic [AW-1:0]   prev_addr;
        int              waited;

        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
`ifdef ROM_ARB_STATS_EN
        stats_clear = 1'b0;
`endif

        // Hand-derived grant sequence from reset; addresses {a3,a2,a1,a0} = {25,12,7,3}.
        tab_addrs = {5'd25, 5'd12, 5'd7, 5'd3};
        tab[0]  = '{4'b0000, 4'b0000, 5'd0};
        tab[1]  = '{4'b1111, 4'b0001, 5'd3};
        tab[2]  = '{4'b1111, 4'b0010, 5'd7};
        tab[3]  = '{4'b1111, 4'b0100, 5'd12};
        tab[4]  = '{4'b1111, 4'b1000, 5'd25};
        tab[5]  = '{4'b1111, 4'b0001, 5'd3};
        tab[6]  = '{4'b0000, 4'b0000, 5'd3};
        tab[7]  = '{4'b1001, 4'b1000, 5'd25};
        tab[8]  = '{4'b1001, 4'b0001, 5'd3};
        tab[9]  = '{4'b0100, 4'b0100, 5'd12};
        tab[10] = '{4'b0100, 4'b0100, 5'd12};
        tab[11] = '{4'b0011, 4'b0001, 5'd3};
        tab[12] = '{4'b0011, 4'b0010, 5'd7};
        tab[13] = '{4'b0000, 4'b0000, 5'd7};

        @(posedge clock); #1;
        do_reset();
        prev_ready = '0; prev_addr = '0;
        for (int i = 0; i < 14; i++) begin
            bus.req_valid = tab[i].valid;
            bus.req_addr  = tab_addrs;
            #3;
            check("tab_ready", bus.req_ready, tab[i].ready);
            check("tab_rom_addr", bus.rom_addr, tab[i].addr);
            check("tab_rsp_valid", bus.rsp_valid, prev_ready);
            if (prev_ready != '0) check("tab_rsp_data", bus.rsp_data, rom_word(prev_addr));
            prev_ready = tab[i].ready;
            prev_addr  = tab[i].addr;
            @(posedge clock); #1;
        end

        // Single requester 2 streams every address.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            cycle(4'b0100, {5'd0, 5'(k), 5'd0, 5'd0}, seen);
            if (k == 0) begin
                #3;
                check("rom_word0", bus.rsp_data, 32'hD3301861);
            end
        end
        cycle(4'b0000, '0, seen);

        // All requesters active from reset rotate 0,1,2,3,...
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, N*AW'($urandom), seen);
            check("all_order", seen, N'(1) << (k % N));
        end

        // Mid-traffic reset with a response pending.
        do_reset();
        a = {5'd9, 5'd18, 5'd27, 5'd4};
        for (int k = 0; k < 3; k++) cycle(4'b1111, a, seen);
        check("pend_before_rst", bus.rsp_valid, N'(1) << m_pend_id);
        reset = 1'b0;
        #1;
        check("rst_async_rsp", bus.rsp_valid, 0);
        check("rst_ptr_ready", bus.req_ready, 4'b0001);
        check("rst_ptr_addr", bus.rom_addr, 5'd4);
        bus.req_valid = '0;
        @(posedge clock); #1;
        reset = 1'b1;
        m_ptr = 0; m_pend = 1'b0; m_last = '0;
        cycle(4'b0000, a, seen);
        cycle(4'b0000, a, seen);

        // Requests 1 and 3 with pointer at 2, then requester 0 joins.
        cycle(4'b0010, a, seen);
        cycle(4'b1010, a, seen);
        check("t4_first", seen, 4'b1000);
        cycle(4'b0010, a, seen);
        check("t4_second", seen, 4'b0010);
        waited = 0;
        seen   = '0;
        while (!seen[0] && waited < 8) begin
            cycle(4'b1111, a, seen);
            if (!seen[0]) waited++;
        end
        check("t4_req0_wait", waited, 2);

        // Idle window: nothing granted, address and pointer hold.
        for (int k = 0; k < 5; k++) cycle(4'b0000, N*AW'($urandom), seen);
        cycle(4'b1111, a, seen);

        // Randomised traffic obeying the hold-until-ready rule.
        do_reset();
        v = '0; a = '0;
        for (int k = 0; k < 400; k++) begin
            cycle(v, a, seen);
            for (int i = 0; i < N; i++) begin
                if (seen[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    a[i*AW +: AW] = AW'($urandom);
                end else if (!v[i]) begin
                    v[i] = ($urandom_range(0, 2) == 0);
                    a[i*AW +: AW] = AW'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
        end
        cycle(4'b0000, a, seen);

`ifdef ROM_ARB_STATS_EN
        do_reset();
        check("cnt_reset", grant_count, 0);
        for (int k = 0; k < 20; k++) cycle(4'b0001, '0, seen);
        check("cnt_saturate", grant_count, 16'h000F);
        stats_clear = 1'b1;
        cycle(4'b0001, '0, seen);
        stats_clear = 1'b0;
        check("cnt_clear_wins", grant_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
